// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (fetch/execute) arbiter onto one memory port, with
//            registered one-hot grant and shared registered read data.
//            Define MEM_ARB_RR_EN for round-robin tie-break (default: execute wins).
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int M_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               f_req,
    input  logic               f_we,
    input  logic [M_WIDTH-1:0] f_addr,
    input  logic [M_WIDTH-1:0] f_wdata,
    input  logic [1:0]         f_acc_width,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [M_WIDTH-1:0] d_addr,
    input  logic [M_WIDTH-1:0] d_wdata,
    input  logic [1:0]         d_acc_width,
    output logic               f_ready,
    output logic               d_ready,
    output logic [M_WIDTH-1:0] rdata,
    output logic [1:0]         gnt,
    output logic               mem_req,
    output logic               mem_we,
    output logic [M_WIDTH-1:0] mem_addr,
    output logic [M_WIDTH-1:0] mem_data_out,
    output logic [1:0]         mem_acc_width,
    input  logic               mem_ready,
    input  logic [M_WIDTH-1:0] mem_data_in
);

    // State encoding doubles as the one-hot grant value.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GNT_F = 2'b01,
        S_GNT_D = 2'b10
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [M_WIDTH-1:0] r_rdata_q, w_rdata_d;
    logic               w_tie_to_d;

`ifdef MEM_ARB_RR_EN
    logic r_last_q, w_last_d;   // 1 = execute was granted last

    always_comb begin
        w_tie_to_d = ~r_last_q;
        w_last_d   = r_last_q;
        if (r_state_q == S_IDLE && w_state_d != S_IDLE)
            w_last_d = (w_state_d == S_GNT_D);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_last_q <= 1'b0;
        else        r_last_q <= w_last_d;
    end
`else
    always_comb w_tie_to_d = 1'b1;
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_rdata_d = r_rdata_q;
        case (r_state_q)
            S_IDLE: begin
                if (f_req && d_req)
                    w_state_d = w_tie_to_d ? S_GNT_D : S_GNT_F;
                else if (f_req)
                    w_state_d = S_GNT_F;
                else if (d_req)
                    w_state_d = S_GNT_D;
            end
            S_GNT_F: begin
                if (mem_ready && !f_we)
                    w_rdata_d = mem_data_in;
                // Completion and abort both return to IDLE, forcing an idle gap.
                if (mem_ready || !f_req)
                    w_state_d = S_IDLE;
            end
            S_GNT_D: begin
                if (mem_ready && !d_we)
                    w_rdata_d = mem_data_in;
                if (mem_ready || !d_req)
                    w_state_d = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= S_IDLE;
            r_rdata_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_rdata_q <= w_rdata_d;
        end
    end

    // Outputs are forced to idle values while reset is held low.
    always_comb begin
        gnt           = 2'b00;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_data_out  = '0;
        mem_acc_width = 2'b00;
        f_ready       = 1'b0;
        d_ready       = 1'b0;
        if (rst_n) begin
            gnt = r_state_q;
            case (r_state_q)
                S_GNT_F: begin
                    mem_req       = 1'b1;
                    mem_we        = f_we;
                    mem_addr      = f_addr;
                    mem_data_out  = f_wdata;
                    mem_acc_width = f_acc_width;
                    f_ready       = mem_ready;
                end
                S_GNT_D: begin
                    mem_req       = 1'b1;
                    mem_we        = d_we;
                    mem_addr      = d_addr;
                    mem_data_out  = d_wdata;
                    mem_acc_width = d_acc_width;
                    d_ready       = mem_ready;
                end
                default: ;
            endcase
        end
    end

    assign rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed and random stimulus for mem_arbiter checked against a
//            transaction-level reference model (default tie-break build).
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int M_WIDTH = 8;

    logic               clk, rst_n;
    logic               f_req, f_we, d_req, d_we, mem_ready;
    logic [M_WIDTH-1:0] f_addr, f_wdata, d_addr, d_wdata, mem_data_in;
    logic [1:0]         f_acc_width, d_acc_width;
    logic               f_ready, d_ready, mem_req, mem_we;
    logic [M_WIDTH-1:0] rdata, mem_addr, mem_data_out;
    logic [1:0]         gnt, mem_acc_width;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the memory (0 none, 1 fetch, 2 execute) and the read-data latch.
    int                 m_own   = 0;
    logic [M_WIDTH-1:0] m_rdata = '0;

    mem_arbiter #(.M_WIDTH(M_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata), .f_acc_width(f_acc_width),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_acc_width(d_acc_width),
        .f_ready(f_ready), .d_ready(d_ready), .rdata(rdata), .gnt(gnt),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .mem_acc_width(mem_acc_width), .mem_ready(mem_ready), .mem_data_in(mem_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        bit                 live;
        logic [1:0]         e_gnt;
        logic               e_we;
        logic [M_WIDTH-1:0] e_addr, e_data;
        logic [1:0]         e_acc;
        live   = rst_n && (m_own != 0);
        e_gnt  = !rst_n ? 2'b00 : (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
        e_we   = !live ? 1'b0 : (m_own == 1) ? f_we        : d_we;
        e_addr = !live ? '0   : (m_own == 1) ? f_addr      : d_addr;
        e_data = !live ? '0   : (m_own == 1) ? f_wdata     : d_wdata;
        e_acc  = !live ? '0   : (m_own == 1) ? f_acc_width : d_acc_width;
        chk("gnt",           gnt,           e_gnt);
        chk("mem_req",       mem_req,       live);
        chk("mem_we",        mem_we,        e_we);
        chk("mem_addr",      mem_addr,      e_addr);
        chk("mem_data_out",  mem_data_out,  e_data);
        chk("mem_acc_width", mem_acc_width, e_acc);
        chk("f_ready",       f_ready,       rst_n && m_own == 1 && mem_ready);
        chk("d_ready",       d_ready,       rst_n && m_own == 2 && mem_ready);
        chk("rdata",         rdata,         m_rdata);
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic ref_tick();
        int                 n_own;
        logic [M_WIDTH-1:0] n_rdata;
        bit                 port_req, port_we;
        n_own   = m_own;
        n_rdata = m_rdata;
        if (!rst_n) begin
            n_own   = 0;
            n_rdata = '0;
        end else if (m_own == 0) begin
            if (d_req)      n_own = 2;   // execute wins any tie
            else if (f_req) n_own = 1;
        end else begin
            port_req = (m_own == 1) ? f_req : d_req;
            port_we  = (m_own == 1) ? f_we  : d_we;
            if (mem_ready && !port_we) n_rdata = mem_data_in;
            if (mem_ready || !port_req) n_own = 0;
        end
        @(posedge clk);
        m_own   = n_own;
        m_rdata = n_rdata;
        #1;
    endtask

    task automatic cyc();
        #1;
        check_model();
        ref_tick();
    endtask

    initial begin
        rst_n = 1'b0; f_req = 0; f_we = 0; d_req = 0; d_we = 0; mem_ready = 0;
        f_addr = '0; f_wdata = '0; d_addr = '0; d_wdata = '0; mem_data_in = '0;
        f_acc_width = 2'b00; d_acc_width = 2'b00;
        ref_tick();
        cyc();
        chk("reset_gnt", gnt, 2'b00);
        chk("reset_rdata", rdata, 8'h00);
        rst_n = 1'b1;
        cyc();

        // Single read, memory answers on the third granted cycle.
        d_req = 1; d_addr = 8'h40; d_we = 0;
        cyc();
        chk("rd_gnt", gnt, 2'b10);
        #1;
        chk("rd_mem_addr", mem_addr, 8'h40);
        chk("rd_mem_req", mem_req, 1'b1);
        cyc();
        cyc();
        mem_ready = 1; mem_data_in = 8'h5A;
        #1;
        chk("rd_d_ready", d_ready, 1'b1);
        cyc();
        chk("rd_rdata", rdata, 8'h5A);
        chk("rd_gnt_idle", gnt, 2'b00);
        d_req = 0; mem_ready = 0;
        cyc();

        // Collision: execute first, then fetch after one idle cycle.
        f_req = 1; f_addr = 8'h21; d_req = 1; d_addr = 8'h31;
        cyc();
        chk("col_first_gnt", gnt, 2'b10);
        mem_ready = 1; mem_data_in = 8'h11;
        cyc();
        chk("col_idle_gnt", gnt, 2'b00);
        d_req = 0; mem_ready = 0;
        cyc();
        chk("col_second_gnt", gnt, 2'b01);
        mem_ready = 1; mem_data_in = 8'h22;
        #1;
        chk("col_f_ready", f_ready, 1'b1);
        cyc();
        f_req = 0; mem_ready = 0;
        chk("col_rdata", rdata, 8'h22);
        cyc();

        // Write through the fetch port leaves rdata alone.
        f_req = 1; f_we = 1; f_addr = 8'h10; f_wdata = 8'hC3; f_acc_width = 2'b10;
        cyc();
        #1;
        chk("wr_mem_we", mem_we, 1'b1);
        chk("wr_mem_addr", mem_addr, 8'h10);
        chk("wr_mem_data", mem_data_out, 8'hC3);
        chk("wr_mem_acc", mem_acc_width, 2'b10);
        mem_ready = 1; mem_data_in = 8'h77;
        cyc();
        chk("wr_rdata_hold", rdata, 8'h22);
        f_req = 0; f_we = 0; mem_ready = 0;
        cyc();

        // Reset in the middle of an execute access.
        d_req = 1; d_we = 0;
        cyc();
        chk("rst_gnt_before", gnt, 2'b10);
        rst_n = 0;
        cyc();
        chk("rst_gnt_after", gnt, 2'b00);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        d_req = 0; rst_n = 1;
        cyc();

        // Abort by dropping the request, then a stray ready in IDLE.
        d_req = 1;
        cyc();
        chk("ab_gnt", gnt, 2'b10);
        d_req = 0;
        cyc();
        chk("ab_gnt_idle", gnt, 2'b00);
        mem_ready = 1; mem_data_in = 8'hFF;
        #1;
        chk("stray_d_ready", d_ready, 1'b0);
        chk("stray_f_ready", f_ready, 1'b0);
        cyc();
        chk("stray_rdata", rdata, 8'h00);
        mem_ready = 0;
        cyc();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst_n       = ($urandom_range(0, 59) != 0);
            f_req       = ($urandom_range(0, 2) != 0);
            d_req       = ($urandom_range(0, 2) != 0);
            f_we        = $urandom_range(0, 1);
            d_we        = $urandom_range(0, 1);
            f_addr      = M_WIDTH'($urandom);
            d_addr      = M_WIDTH'($urandom);
            f_wdata     = M_WIDTH'($urandom);
            d_wdata     = M_WIDTH'($urandom);
            f_acc_width = 2'($urandom_range(0, 2));
            d_acc_width = 2'($urandom_range(0, 2));
            mem_ready   = ($urandom_range(0, 3) == 0);
            mem_data_in = M_WIDTH'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
